// File: rtl/engine_pkg.sv
// Shared types and constants for the Mandelbrot pixel engines.
// ENGINE_PALETTE_EN selects the palette colouring in mandel_engine.
package engine_pkg;

  localparam int DEFAULT_FRAC_BITS = 24;

  typedef enum logic [1:0] {
    SETUP,
    ITERATE,
    HOLD
  } engine_state_t;

  // All ones can never be a valid on-screen coordinate.
  localparam logic [63:0] SENTINEL = '1;

  localparam logic [23:0] PALETTE [16] = '{
    24'h421E0F, 24'h19071A, 24'h09012F, 24'h040449,
    24'h000764, 24'h0C2C8A, 24'h1852B1, 24'h397DD1,
    24'h86B5E5, 24'hD3ECF8, 24'hF1E9BF, 24'hF8C95F,
    24'hFFAA00, 24'hCC8000, 24'h995700, 24'h6A3403
  };

  // |z|^2 must strictly exceed this value (4.0 in fixed point) to escape.
  function automatic longint escape_threshold(input int frac_bits);
    return longint'(4) << frac_bits;
  endfunction

endpackage

// File: rtl/mandel_step.sv
// Combinational single Mandelbrot iteration: z' = z^2 + c and escape test on z.
module mandel_step
  import engine_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
  input  logic signed [DATA_WIDTH-1:0] i_zr,
  input  logic signed [DATA_WIDTH-1:0] i_zi,
  input  logic signed [DATA_WIDTH-1:0] i_c_re,
  input  logic signed [DATA_WIDTH-1:0] i_c_im,
  output logic signed [DATA_WIDTH-1:0] o_zr_next,
  output logic signed [DATA_WIDTH-1:0] o_zi_next,
  output logic                         o_escape
);

  localparam int PW = 2 * DATA_WIDTH;
  typedef logic signed [PW-1:0] wide_t;

  wide_t w_zr2;
  wide_t w_zi2;
  wide_t w_zri;

  assign w_zr2 = (wide_t'(i_zr) * wide_t'(i_zr)) >>> FRAC_BITS;
  assign w_zi2 = (wide_t'(i_zi) * wide_t'(i_zi)) >>> FRAC_BITS;
  assign w_zri = (wide_t'(i_zr) * wide_t'(i_zi)) >>> FRAC_BITS;

  // The magnitude test stays at full width so large z never wraps back under 4.
  assign o_escape  = (w_zr2 + w_zi2) > wide_t'(escape_threshold(FRAC_BITS));
  assign o_zr_next = DATA_WIDTH'(w_zr2 - w_zi2 + wide_t'(i_c_re));
  assign o_zi_next = DATA_WIDTH'((w_zri <<< 1) + wide_t'(i_c_im));

endmodule

// File: rtl/mandel_engine.sv
// One Mandelbrot engine: iterates its interleaved share of the raster and holds
// each pixel until taken. Define ENGINE_PALETTE_EN for palette colouring.
module mandel_engine
  import engine_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = DEFAULT_FRAC_BITS,
  parameter int RBG_SIZE      = 24,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES   = 6,
  parameter int ENGINE_ID     = 0,
  parameter int MAX_ITER      = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] x0_i,
  input  logic signed [DATA_WIDTH-1:0] y0_i,
  input  logic signed [DATA_WIDTH-1:0] step_i,
  input  logic                         taken_i,
  output logic        [DATA_WIDTH-1:0] xpixel_o,
  output logic        [DATA_WIDTH-1:0] ypixel_o,
  output logic        [RBG_SIZE-1:0]   colour_o,
  output logic                         busy_o,
  output logic                         frame_done_o
);

  localparam int PW = 2 * DATA_WIDTH;
  typedef logic signed [PW-1:0] wide_t;

  localparam logic [DATA_WIDTH-1:0] SENT     = SENTINEL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] HOME_X   = DATA_WIDTH'(ENGINE_ID);
  localparam logic [7:0]            ITER_CAP = 8'(MAX_ITER);

  engine_state_t                r_state;
  logic        [DATA_WIDTH-1:0] r_x;
  logic        [DATA_WIDTH-1:0] r_y;
  logic signed [DATA_WIDTH-1:0] r_x0;
  logic signed [DATA_WIDTH-1:0] r_y0;
  logic signed [DATA_WIDTH-1:0] r_step;
  logic signed [DATA_WIDTH-1:0] r_c_re;
  logic signed [DATA_WIDTH-1:0] r_c_im;
  logic signed [DATA_WIDTH-1:0] r_zr;
  logic signed [DATA_WIDTH-1:0] r_zi;
  logic        [7:0]            r_iter;
  logic        [DATA_WIDTH-1:0] r_xpixel;
  logic        [DATA_WIDTH-1:0] r_ypixel;
  logic        [RBG_SIZE-1:0]   r_colour;
  logic                         r_busy;
  logic                         r_frame_done;

  logic signed [DATA_WIDTH-1:0] w_zr_next;
  logic signed [DATA_WIDTH-1:0] w_zi_next;
  logic                         w_escape;
  logic                         w_done;
  logic        [DATA_WIDTH-1:0] w_x_inc;
  logic        [DATA_WIDTH-1:0] w_x_next;
  logic        [DATA_WIDTH-1:0] w_y_next;
  logic                         w_wrap;
  logic                         w_frame_end;
  logic        [RBG_SIZE-1:0]   w_escape_colour;

  mandel_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_step (
    .i_zr      (r_zr),
    .i_zi      (r_zi),
    .i_c_re    (r_c_re),
    .i_c_im    (r_c_im),
    .o_zr_next (w_zr_next),
    .o_zi_next (w_zi_next),
    .o_escape  (w_escape)
  );

  assign w_done = w_escape || (r_iter == ITER_CAP);

  // Next raster position owned by this engine: stride NUM_ENGINES, wrap into the next line.
  assign w_x_inc     = r_x + DATA_WIDTH'(NUM_ENGINES);
  assign w_wrap      = w_x_inc >= DATA_WIDTH'(SCREEN_WIDTH);
  assign w_x_next    = w_wrap ? w_x_inc - DATA_WIDTH'(SCREEN_WIDTH) : w_x_inc;
  assign w_y_next    = r_y + DATA_WIDTH'(w_wrap);
  assign w_frame_end = w_y_next == DATA_WIDTH'(SCREEN_HEIGHT);

`ifdef ENGINE_PALETTE_EN
  assign w_escape_colour = RBG_SIZE'(PALETTE[r_iter[3:0]]);
`else
  assign w_escape_colour = RBG_SIZE'({r_iter, r_iter, r_iter});
`endif

  // NOTE: every register here is sequential state, so only non-blocking assignments
  // are used; blocking ones would let later statements see same-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SETUP;
      r_x          <= HOME_X;
      r_y          <= '0;
      r_x0         <= x0_i;
      r_y0         <= y0_i;
      r_step       <= step_i;
      r_c_re       <= '0;
      r_c_im       <= '0;
      r_zr         <= '0;
      r_zi         <= '0;
      r_iter       <= '0;
      r_xpixel     <= SENT;
      r_ypixel     <= SENT;
      r_colour     <= '0;
      r_busy       <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        SETUP: begin
          r_c_re  <= r_x0 + DATA_WIDTH'(wide_t'(r_x) * wide_t'(r_step));
          r_c_im  <= r_y0 - DATA_WIDTH'(wide_t'(r_y) * wide_t'(r_step));
          r_zr    <= '0;
          r_zi    <= '0;
          r_iter  <= '0;
          r_state <= ITERATE;
        end

        ITERATE: begin
          if (w_done) begin
            r_colour <= (r_iter == ITER_CAP) ? '0 : w_escape_colour;
            r_xpixel <= r_x;
            r_ypixel <= r_y;
            r_busy   <= 1'b0;
            r_state  <= HOLD;
          end else begin
            r_zr   <= w_zr_next;
            r_zi   <= w_zi_next;
            r_iter <= r_iter + 8'd1;
          end
        end

        HOLD: begin
          if (taken_i) begin
            r_xpixel <= SENT;
            r_ypixel <= SENT;
            r_busy   <= 1'b1;
            r_state  <= SETUP;
            if (w_frame_end) begin
              r_x          <= HOME_X;
              r_y          <= '0;
              r_x0         <= x0_i;
              r_y0         <= y0_i;
              r_step       <= step_i;
              r_frame_done <= 1'b1;
            end else begin
              r_x <= w_x_next;
              r_y <= w_y_next;
            end
          end
        end

        default: r_state <= SETUP;
      endcase
    end
  end

  assign xpixel_o     = r_xpixel;
  assign ypixel_o     = r_ypixel;
  assign colour_o     = r_colour;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_mandel_engine.sv
// Self-checking bench for mandel_engine (engine 5 of 6, 640-wide, 4-line frame).
module tb_mandel_engine;

  localparam int W    = 640;
  localparam int H    = 4;
  localparam int NE   = 6;
  localparam int EID  = 5;
  localparam int MAXI = 255;
  localparam int F    = 24;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [31:0] x0_i = 32'sh0300_0000;
  logic signed [31:0] y0_i = '0;
  logic signed [31:0] step_i = '0;
  logic               taken_i = 1'b0;
  logic        [31:0] xpixel_o;
  logic        [31:0] ypixel_o;
  logic        [23:0] colour_o;
  logic               busy_o;
  logic               frame_done_o;

  always #5 clk = ~clk;

  mandel_engine #(
    .DATA_WIDTH    (32),
    .FRAC_BITS     (F),
    .RBG_SIZE      (24),
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .NUM_ENGINES   (NE),
    .ENGINE_ID     (EID),
    .MAX_ITER      (MAXI)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .x0_i         (x0_i),
    .y0_i         (y0_i),
    .step_i       (step_i),
    .taken_i      (taken_i),
    .xpixel_o     (xpixel_o),
    .ypixel_o     (ypixel_o),
    .colour_o     (colour_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: parameters latched at frame start and pixel index within frame.
  int m_x0, m_y0, m_step, m_k;
  int fd_highs;

  typedef struct {
    string name;
    int    x0;
    int    y0;
    int    step;
    int    iter;
    int    lat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Escape-time count from the plain recurrence, with fixed-point products at 64 bits.
  function automatic int model_iter(input int c_re, input int c_im);
    longint zr = 0, zi = 0, zr2, zi2, zri;
    for (int it = 0; it <= MAXI; it++) begin
      zr2 = (zr * zr) >>> F;
      zi2 = (zi * zi) >>> F;
      zri = (zr * zi) >>> F;
      if (zr2 + zi2 > (longint'(4) << F) || it == MAXI) return it;
      zr = longint'(int'(zr2 - zi2 + longint'(c_re)));
      zi = longint'(int'(2 * zri + longint'(c_im)));
    end
    return MAXI;
  endfunction

  function automatic logic [23:0] model_colour(input int it);
    logic [7:0] g;
    g = 8'(it);
    if (it == MAXI) return 24'h000000;
`ifdef ENGINE_PALETTE_EN
    return engine_pkg::PALETTE[g[3:0]];
`else
    return {g, g, g};
`endif
  endfunction

  task automatic latch_model();
    m_x0   = x0_i;
    m_y0   = y0_i;
    m_step = step_i;
    m_k    = 0;
  endtask

  task automatic do_reset(input int x0, input int y0, input int step);
    @(negedge clk);
    reset   = 1'b1;
    taken_i = 1'b0;
    x0_i    = x0;
    y0_i    = y0;
    step_i  = step;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    latch_model();
  endtask

  task automatic wait_hold(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    while (lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (frame_done_o) fd_highs++;
      if (xpixel_o !== SENT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL hold_timeout: no pixel after %0d cycles, required <= %0d", lat, MAXI + 2);
    end
  endtask

  // Waits for the next pixel and compares it with the model (or forced iter/latency).
  task automatic expect_pixel(input string tag, input int f_iter = -1, input int f_lat = -1);
    int p, x, y, it, lat;
    bit ok;
    p  = EID + m_k * NE;
    x  = p % W;
    y  = p / W;
    it = (f_iter >= 0) ? f_iter : model_iter(m_x0 + x * m_step, m_y0 - y * m_step);
    wait_hold(lat, ok);
    if (ok) begin
      check({tag, "_x"}, xpixel_o, 32'(x));
      check({tag, "_y"}, ypixel_o, 32'(y));
      check({tag, "_colour"}, colour_o, model_colour(it));
      check({tag, "_latency"}, 64'(lat), 64'((f_lat >= 0) ? f_lat : 2 + it));
      check({tag, "_busy"}, busy_o, 1'b0);
    end
  endtask

  task automatic take(output bit frame_end);
    frame_end = (EID + (m_k + 1) * NE) >= W * H;
    taken_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    taken_i = 1'b0;
    check("take_sentinel_x", xpixel_o, SENT);
    check("take_sentinel_y", ypixel_o, SENT);
    check("take_busy", busy_o, 1'b1);
    check("take_frame_done", frame_done_o, frame_end);
    if (frame_end) latch_model();
    else m_k++;
  endtask

  initial begin
    int  dev, cnt;
    bit  fe;

    tbl[0] = '{"escape_3", 32'h0300_0000, 0, 0, 1, 3};
    tbl[1] = '{"inset_0", 0, 0, 0, MAXI, MAXI + 2};
    tbl[2] = '{"escape_2", 32'h0200_0000, 0, 0, 2, 4};
    tbl[3] = '{"edge_m2", 32'hFE00_0000, 0, 0, MAXI, MAXI + 2};
    tbl[4] = '{"cycle_i", 0, 32'h0100_0000, 0, MAXI, MAXI + 2};
    tbl[5] = '{"step_2", 32'h01B0_0000, 0, 32'h0010_0000, 2, 4};

    // Reset state, held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_x", xpixel_o, SENT);
    check("rst_y", ypixel_o, SENT);
    check("rst_colour", colour_o, 24'h0);
    check("rst_busy", busy_o, 1'b1);
    check("rst_frame_done", frame_done_o, 1'b0);
    reset = 1'b0;
    latch_model();
    expect_pixel("first", 1, 3);

    // Handshake: outputs stay put while taken_i is low, then advance by NE.
    dev = 0;
    repeat (50) begin
      @(negedge clk);
      if (xpixel_o !== 32'(EID) || ypixel_o !== 32'd0 || colour_o !== model_colour(1) ||
          busy_o !== 1'b0)
        dev++;
    end
    check("hold_stable", 64'(dev), 64'd0);
    take(fe);
    expect_pixel("advance");

    // Table of single-pixel vectors with hand-derived iteration counts.
    for (int i = 0; i < 6; i++) begin
      do_reset(tbl[i].x0, tbl[i].y0, tbl[i].step);
      expect_pixel(tbl[i].name, tbl[i].iter, tbl[i].lat);
    end

    // Whole frame with auto-take; x0 changes mid-frame and must apply only next frame.
    do_reset(32'h0300_0000, 0, 0);
    fd_highs = 0;
    fe  = 1'b0;
    cnt = 0;
    while (!fe && cnt < 1000) begin
      expect_pixel("frame");
      if (cnt == 1) x0_i = 32'h0200_0000;
      take(fe);
      cnt++;
    end
    check("frame_pixel_count", 64'(cnt), 64'((W * H - EID + NE - 1) / NE));
    check("frame_done_extra", 64'(fd_highs), 64'd0);
    expect_pixel("frame_restart");

    // Reset during a long in-set iteration, with a stale take asserted alongside.
    do_reset(0, 0, 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    taken_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_x", xpixel_o, SENT);
    check("midrst_y", ypixel_o, SENT);
    check("midrst_busy", busy_o, 1'b1);
    check("midrst_frame_done", frame_done_o, 1'b0);
    reset   = 1'b0;
    taken_i = 1'b0;
    latch_model();
    expect_pixel("midrst_restart", MAXI, MAXI + 2);

    // Random windows around the set, three pixels each.
    for (int f = 0; f < 10; f++) begin
      do_reset(-(9 << 22) + int'($urandom_range(0, 3 << 24)),
               -(3 << 23) + int'($urandom_range(0, 3 << 24)),
               int'($urandom_range(0, 1 << 20)) - (1 << 19));
      for (int j = 0; j < 3; j++) begin
        expect_pixel("rand");
        take(fe);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mandel_engine.md
# mandel_engine

Per-engine Mandelbrot pixel producer on the engine side of the pixel combinator interface. It computes the pixels assigned to engine `ENGINE_ID` in raster-interleaved order. Each finished pixel is presented as (x, y, colour) until the combinator returns `taken_i`, and the engine then advances to its next pixel. `NUM_ENGINES` instances feed one combinator.

## Interface
- `DATA_WIDTH`, 32: coordinate and fixed-point word width.
- `FRAC_BITS`, 24: fractional bits of the signed fixed-point format (Q8.24 at defaults; integer bits ≥ 4 required).
- `RBG_SIZE`, 24: colour width.
- `SCREEN_WIDTH`, 640: pixels per line.
- `SCREEN_HEIGHT`, 480: lines per frame.
- `NUM_ENGINES`, 6: engines sharing the frame (< `SCREEN_WIDTH`).
- `ENGINE_ID`, 0: this engine's index, 0..`NUM_ENGINES`-1.
- `MAX_ITER`, 255: iteration cap (≤ 255).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `x0_i` in `DATA_WIDTH`: signed real part of pixel (0,0); latched at frame start.
- `y0_i` in `DATA_WIDTH`: signed imaginary part of pixel (0,0); latched at frame start.
- `step_i` in `DATA_WIDTH`: signed per-pixel increment; latched at frame start.
- `taken_i` in 1: combinator has consumed the presented pixel.
- `xpixel_o` out `DATA_WIDTH`: presented x, or SENTINEL.
- `ypixel_o` out `DATA_WIDTH`: presented y, or SENTINEL.
- `colour_o` out `RBG_SIZE`: presented colour.
- `busy_o` out 1: high in SETUP/ITERATE.
- `frame_done_o` out 1: one-cycle pulse after the engine's last pixel of a frame is taken.

## Operation
- States: SETUP, ITERATE, HOLD. After reset the engine is in SETUP.
- Reset values:
  - Engine position: x = `ENGINE_ID`, y = 0.
  - `xpixel_o` = `ypixel_o` = SENTINEL (all ones).
  - `colour_o` = 0, `busy_o` = 1, `frame_done_o` = 0.
  - Latched x0/y0/step are loaded from the inputs.
- SETUP (1 cycle):
  - c_re = x0 + x·step, c_im = y0 − y·step; products truncated arithmetically to `DATA_WIDTH`.
  - zr = zi = 0, iter = 0. Go to ITERATE.
- ITERATE (1 cycle per step). Compute:
  - zr2 = (zr·zr)>>>F
  - zi2 = (zi·zi)>>>F
  - zri = (zr·zi)>>>F
  - All products use 2·`DATA_WIDTH` signed intermediates.
- ITERATE exit test:
  - If zr2+zi2 > (4<<F), or iter == `MAX_ITER`: go to HOLD with the final iter.
  - Otherwise: zr ← zr2−zi2+c_re, zi ← 2·zri+c_im, iter ← iter+1.
- Entering HOLD:
  - Registers colour from iter.
  - Drives `xpixel_o`/`ypixel_o` = current x/y.
- HOLD: outputs stay stable until `taken_i` is sampled high. Then, on the next edge:
  - Outputs return to SENTINEL.
  - Position advances: x ← x+`NUM_ENGINES`. If the result is ≥ `SCREEN_WIDTH`, x ← x−`SCREEN_WIDTH` and y ← y+1.
  - If the new y == `SCREEN_HEIGHT`: x ← `ENGINE_ID`, y ← 0, x0/y0/step re-latched, `frame_done_o` pulses.
  - Go to SETUP.
- `taken_i` outside HOLD is ignored.
- SENTINEL never equals a valid coordinate, so the combinator never matches an engine that is not in HOLD.
- Colour: iter == `MAX_ITER` (inside set) → 24'h000000 in every configuration.

## Timing
- Pixel latency from SETUP entry to HOLD outputs valid is 2+n cycles, where n is the number of z updates performed.
  - c = 3+0i: n = 1, latency 3.
  - In-set c: n = `MAX_ITER`, latency 2+`MAX_ITER`.
- Turnaround: `taken_i` high in cycle t means SENTINEL on outputs at t+1 and SETUP at t+1.
- `frame_done_o` is high in the same cycle SENTINEL reappears after the frame's last pixel.
- Reset in any state, including mid-ITERATE or mid-HOLD, aborts the pixel and returns to the reset values on the next edge.
- No output glitches: all outputs are registered.

## Configuration
- `ENGINE_PALETTE_EN` defined: escaped-pixel colour = 16-entry 24-bit palette[iter[3:0]].
- Not defined: grayscale {g,g,g}, with g = iter[7:0].
- Inside-set black in both cases.

## Structure
- Package `engine_pkg` holds:
  - `FRAC_BITS` default.
  - state enum `engine_state_t` {SETUP, ITERATE, HOLD}.
  - SENTINEL constant.
  - palette constant array.
  - escape threshold function.
- Sub-module `mandel_step`: combinational single-iteration datapath.
  - Inputs: zr, zi, c_re, c_im.
  - Outputs: next zr, next zi, escape flag.
  - Instantiated once by `mandel_engine`.

## Test plan
- Reset check: assert `reset` for 2 cycles → outputs SENTINEL/0, `busy_o`=1, `frame_done_o`=0. With `taken_i` held low, the first HOLD presents (`ENGINE_ID`, 0).
- Escape point: x0=3.0 (0x03000000), y0=0, step=0 → HOLD at cycle 3 after reset release, iter=1, colour = g=1 grayscale or palette[1].
- In-set point: x0=y0=step=0, `MAX_ITER`=255 → HOLD after 257 cycles, colour 0x000000.
- Handshake: hold `taken_i` low for 50 cycles in HOLD → outputs stable. Pulse `taken_i` once → SENTINEL next cycle and x advances by 6.
- Wrap and frame end: `ENGINE_ID`=5, 6 engines, auto-take every HOLD.
  - x sequence 5, 11, …, 635, then (1, y=1).
  - After the last pixel at y=479, `frame_done_o` pulses once and the next pixel is (5, 0).
- Mid-operation reset: assert `reset` in cycle 40 of a 257-cycle iteration → SENTINEL next cycle, restart at (`ENGINE_ID`, 0), no stale `taken_i` effect.
